// File: rtl/mul_seq_16.sv
// Sequential unsigned shift-add multiplier. It borrows the shared execute-stage CLA for its
// additions and runs 16 iterations per product, with an optional single-cycle zero-operand bypass.
module mul_seq_16 #(
    parameter int WIDTH     = 16,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_g
);

    generate
        if (WIDTH != 16) begin : g_width_check
            $error("mul_seq_16: WIDTH must equal the shared CLA width (16)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   mc_r, mc_s;
    logic [WIDTH-1:0]   hi_r, hi_s;
    logic [WIDTH-1:0]   lo_r, lo_s;
    logic [3:0]         cnt_r, cnt_s;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            mc_r    <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            mc_r    <= mc_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and datapath update; flush overrides everything but leaves the data registers intact.
    always_comb begin
        state_s = state_r;
        mc_s    = mc_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        cnt_s   = cnt_r;
        if (flush) begin
            state_s = IDLE;
            cnt_s   = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mc_s  = mcand;
                        lo_s  = mplier;
                        hi_s  = {WIDTH{1'b0}};
                        cnt_s = 4'd0;
                        if (SKIP_ZERO && ((mcand == {WIDTH{1'b0}}) || (mplier == {WIDTH{1'b0}}))) begin
                            lo_s    = {WIDTH{1'b0}};
                            state_s = DONE;
                        end else begin
                            state_s = CALC;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    // Shift {carry, sum, lo} right by one: the sum LSB becomes the next product bit.
                    {hi_s, lo_s} = {add_g & lo_r[0], add_s, lo_r[WIDTH-1:1]};
                    cnt_s        = cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Output decode purely from registered state, so async reset reaches the outputs at once.
    always_comb begin
        in_ready  = (state_r == IDLE);
        out_valid = (state_r == DONE);
        product   = {hi_r, lo_r};
        add_cin   = 1'b0;
        add_a     = {WIDTH{1'b0}};
        add_b     = {WIDTH{1'b0}};
        if (state_r == CALC) begin
            add_a = hi_r;
            if (lo_r[0]) begin
                add_b = mc_r;
            end else begin
                add_b = {WIDTH{1'b0}};
            end
        end else begin
            add_a = {WIDTH{1'b0}};
            add_b = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_mul_seq_16.sv
// Directed and random checks of mul_seq_16; a behavioural 16-bit adder stands in for the shared CLA.
// Two instances cover SKIP_ZERO=1 (main) and SKIP_ZERO=0 (ns).
module tb_mul_seq_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid_ns = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_ready_ns = 1'b1;
    logic [15:0] mcand = 16'd0;
    logic [15:0] mplier = 16'd0;

    logic        in_ready, out_valid, add_cin, add_g;
    logic [31:0] product;
    logic [15:0] add_a, add_b, add_s;
    logic        in_ready_ns, out_valid_ns, add_cin_ns, add_g_ns;
    logic [31:0] product_ns;
    logic [15:0] add_a_ns, add_b_ns, add_s_ns;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign {add_g, add_s}       = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    assign {add_g_ns, add_s_ns} = {1'b0, add_a_ns} + {1'b0, add_b_ns} + {16'd0, add_cin_ns};

    mul_seq_16 #(.WIDTH(16), .SKIP_ZERO(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .mcand(mcand), .mplier(mplier),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_g(add_g)
    );

    mul_seq_16 #(.WIDTH(16), .SKIP_ZERO(1'b0)) u_dut_ns (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_ns), .in_ready(in_ready_ns), .mcand(mcand), .mplier(mplier),
        .out_valid(out_valid_ns), .out_ready(out_ready_ns), .product(product_ns),
        .add_a(add_a_ns), .add_b(add_b_ns), .add_cin(add_cin_ns), .add_s(add_s_ns), .add_g(add_g_ns)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One multiply on the selected instance; hold = cycles out_ready stays low after out_valid.
    task automatic op(input bit ns, input logic [15:0] a, input logic [15:0] b,
                      input int hold, input string tag);
        logic [31:0] exp_p;
        int          exp_lat;
        int          lat;
        exp_p   = {16'd0, a} * {16'd0, b};
        exp_lat = (!ns && (a == 16'd0 || b == 16'd0)) ? 1 : 17;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, ns ? in_ready_ns : in_ready, 32'd1);
        mcand  = a;
        mplier = b;
        if (ns) in_valid_ns = 1'b1;
        else    in_valid    = 1'b1;
        if (hold > 0) out_ready = 1'b0;
        @(negedge clk);
        in_valid    = 1'b0;
        in_valid_ns = 1'b0;
        lat = 1;
        while (!(ns ? out_valid_ns : out_valid) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_product"}, ns ? product_ns : product, exp_p);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_product"}, product, exp_p);
            chk({tag, "_hold_valid"}, out_valid, 32'd1);
            chk({tag, "_hold_in_ready"}, in_ready, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready_after"}, ns ? in_ready_ns : in_ready, 32'd1);
        chk({tag, "_valid_after"}, ns ? out_valid_ns : out_valid, 32'd0);
    endtask

    // Watch a window of cycles and require out_valid to stay low throughout.
    task automatic no_valid(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk(tag, seen, 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        #12;
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_add_ab", {add_a, add_b}, 32'd0);
        chk("rst_add_cin", add_cin, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op(1'b0, 16'h0003, 16'h0005, 0, "m3x5");
        op(1'b0, 16'hFFFF, 16'hFFFF, 0, "mffff");
        op(1'b0, 16'h1234, 16'h0000, 0, "skip");
        op(1'b1, 16'h1234, 16'h0000, 0, "noskip");
        op(1'b0, 16'h8000, 16'h0002, 5, "bp");
        chk("idle_add_ab", {add_a, add_b}, 32'd0);

        // Flush at CALC cycle 8.
        @(negedge clk);
        mcand = 16'h00FF; mplier = 16'h0101; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("calc_add_cin", add_cin, 32'd0);
        chk("calc_in_ready", in_ready, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", in_ready, 32'd1);
        chk("flush_out_valid", out_valid, 32'd0);
        no_valid(25, "flush_no_valid");

        // Flush in IDLE must block acceptance.
        mcand = 16'h0005; mplier = 16'h0007; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", in_ready, 32'd1);
        no_valid(20, "flush_idle_no_valid");
        op(1'b0, 16'h0002, 16'h0003, 0, "after_flush");

        // Async reset mid-CALC.
        @(negedge clk);
        mcand = 16'hFFFF; mplier = 16'hFFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 32'd1);
        chk("arst_out_valid", out_valid, 32'd0);
        chk("arst_product", product, 32'd0);
        chk("arst_add_ab", {add_a, add_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_valid(25, "arst_no_valid");

        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 15) == 0) ra = 16'd0;
            if ($urandom_range(0, 15) == 0) rb = 16'd0;
            op(1'b0, ra, rb, int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
